// File: rtl/uart_mem_loader_pkg.sv
// Shared constants and state encodings for the UART program loader.
package uart_mem_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        LD_SYNC,
        LD_LEN0,
        LD_LEN1,
        LD_DATA,
        LD_DONE,
        LD_ERR
    } ld_state_t;

endpackage

// File: rtl/uart_mem_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, baud counter and RX FSM.
// Emits a one-cycle byte strobe on a good stop bit, or a framing-error strobe.
module uart_rx
    import uart_mem_loader_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_vld,
    output logic       o_frm_err
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = $clog2(DIV + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

    logic [1:0]    r_sync;
    logic          w_rxs;
    rx_state_t     r_state;
    rx_state_t     w_next;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_armed;
    logic          w_half;
    logic          w_full;

    assign w_rxs  = r_sync[1];
    assign w_half = (r_cnt == HALF_M1);
    assign w_full = (r_cnt == FULL_M1);

    always_ff @(posedge clk) begin
        if (!resetn) r_sync <= 2'b11;
        else         r_sync <= {r_sync[0], i_rx};
    end

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= RX_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            RX_IDLE:  if (r_armed && !w_rxs) w_next = RX_START;
            RX_START: if (w_half) w_next = w_rxs ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_full && (r_bit == 3'd7)) w_next = RX_STOP;
            RX_STOP:  if (w_full) w_next = RX_IDLE;
            default:  w_next = RX_IDLE;
        endcase
    end

    always_comb begin
        o_byte     = r_shift;
        o_byte_vld = (r_state == RX_STOP) && w_full && w_rxs;
        o_frm_err  = (r_state == RX_STOP) && w_full && !w_rxs;
    end

    // After any stop sample the line must be seen high again before a new start is accepted.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_armed <= 1'b0;
        end else begin
            if (r_state == RX_IDLE || w_next != r_state || w_full) r_cnt <= '0;
            else                                                   r_cnt <= r_cnt + 1'b1;
            if (r_state == RX_START)                  r_bit <= '0;
            else if (r_state == RX_DATA && w_full)    r_bit <= r_bit + 3'd1;
            if (r_state == RX_STOP && w_full)         r_armed <= 1'b0;
            else if (r_state == RX_IDLE && w_rxs)     r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == RX_DATA && w_full) r_shift <= {w_rxs, r_shift[7:1]};
    end

endmodule

// File: rtl/uart_mem_loader.sv
// Loads a length-prefixed program image from UART into memory, holding the CPU
// for the duration of the load.
module uart_mem_loader
    import uart_mem_loader_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BAUD         = 115_200,
    parameter int WORD_SIZE    = 32,
    parameter int ADDR_W       = 9,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 rx,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [WORD_SIZE-1:0] mem_wd,
    output logic                 mem_we,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 err
);

    localparam int DIV  = CLK_HZ / BAUD;
    localparam int BPW  = WORD_SIZE / 8;
    localparam int BW   = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int TMO  = TIMEOUT_BITS * DIV;
    localparam int TW   = $clog2(TMO + 1);
    localparam int MAXN = 2 ** ADDR_W;

    logic [7:0]           w_byte;
    logic                 w_vld;
    logic                 w_ferr;
    ld_state_t            r_state;
    ld_state_t            w_next;
    logic [15:0]          r_len;
    logic [15:0]          w_n;
    logic [WORD_SIZE-1:0] r_word;
    logic [ADDR_W:0]      r_idx;
    logic [BW-1:0]        r_bcnt;
    logic                 r_we;
    logic [TW-1:0]        r_tmo;
    logic                 w_hold;
    logic                 w_tmo_hit;
    logic                 w_last_word;
    logic                 w_abort;

    uart_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx (
        .clk        (clk),
        .resetn     (resetn),
        .i_rx       (rx),
        .o_byte     (w_byte),
        .o_byte_vld (w_vld),
        .o_frm_err  (w_ferr)
    );

    assign w_n         = {w_byte, r_len[7:0]};
    assign w_hold      = (r_state == LD_LEN0) || (r_state == LD_LEN1) || (r_state == LD_DATA);
    // An arriving byte beats a simultaneous timeout expiry.
    assign w_tmo_hit   = (r_tmo == TW'(TMO - 1)) && !w_vld;
    assign w_abort     = w_ferr || w_tmo_hit;
    // The index is one bit wider than the address so a full-size image never wraps it.
    assign w_last_word = (17'(r_idx) == (17'(r_len) - 17'd1));

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= LD_SYNC;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            LD_SYNC, LD_DONE: if (w_vld && w_byte == SYNC_BYTE) w_next = LD_LEN0;
            LD_LEN0: begin
                if (w_vld)        w_next = LD_LEN1;
                else if (w_abort) w_next = LD_ERR;
            end
            LD_LEN1: begin
                if (w_vld) begin
                    if ({1'b0, w_n} > 17'(MAXN)) w_next = LD_ERR;
                    else if (w_n == 16'd0)       w_next = LD_DONE;
                    else                         w_next = LD_DATA;
                end else if (w_abort) begin
                    w_next = LD_ERR;
                end
            end
            LD_DATA: begin
                if (r_we && w_last_word) w_next = LD_DONE;
                else if (w_abort)        w_next = LD_ERR;
            end
            LD_ERR:  w_next = LD_ERR;
            default: w_next = LD_SYNC;
        endcase
    end

    always_comb begin
        cpu_hold = w_hold;
        done     = (r_state == LD_DONE);
        err      = (r_state == LD_ERR);
        mem_we   = r_we;
        mem_addr = r_idx[ADDR_W-1:0];
        mem_wd   = r_word;
    end

    // The strobe is registered so mem_wd already holds the completed word when mem_we rises.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_len  <= '0;
            r_word <= '0;
            r_idx  <= '0;
            r_bcnt <= '0;
            r_we   <= 1'b0;
            r_tmo  <= '0;
        end else begin
            r_we <= (r_state == LD_DATA) && w_vld && (r_bcnt == BW'(BPW - 1));
            if (r_state == LD_LEN0 && w_vld) r_len[7:0]  <= w_byte;
            if (r_state == LD_LEN1 && w_vld) r_len[15:8] <= w_byte;
            if ((r_state == LD_SYNC || r_state == LD_DONE) && w_next == LD_LEN0) begin
                r_idx  <= '0;
                r_bcnt <= '0;
            end else if (r_we) begin
                r_idx <= r_idx + 1'b1;
            end
            if (r_state == LD_DATA && w_vld) begin
                r_word <= (r_word >> 8) | (WORD_SIZE'(w_byte) << (WORD_SIZE - 8));
                r_bcnt <= (r_bcnt == BW'(BPW - 1)) ? '0 : r_bcnt + 1'b1;
            end
            if (!w_hold || w_vld) r_tmo <= '0;
            else                  r_tmo <= r_tmo + 1'b1;
        end
    end

endmodule
